// File: rtl/bsram_dump.sv
// bsram_dump: reads WORD_COUNT 16-bit BSRAM words from base_addr and streams them
// MSB byte first over an 8N1 UART. Optional macro DUMP_CHECKSUM_EN appends an
// XOR checksum byte of all data bytes before the done pulse.
module bsram_dump #(
    parameter int CLKS_PER_BIT = 234,
    parameter int WORD_COUNT   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_mem,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] base_addr,
    output logic [10:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_wre,
    input  logic [15:0] mem_dout,
    output logic        dump_active,
    output logic        uart_tx,
    output logic        done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, TX_HI, TX_LO, CSUM, FINISH} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, TX_HI, TX_LO, FINISH} state_t;
`endif

    state_t          state;
    logic [10:0]     base;
    logic [10:0]     idx;
    logic [7:0]      lo_byte;
    logic [8:0]      sh;
    logic [3:0]      bit_cnt;
    logic [CW-1:0]   clk_cnt;
    logic [1:0]      lat;
    logic            tx_busy;
    logic            bit_end;
    logic            byte_end;

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] csum;
    assign tx_busy = state == TX_HI || state == TX_LO || state == CSUM;
`else
    assign tx_busy = state == TX_HI || state == TX_LO;
`endif

    assign mem_wre  = 1'b0;
    assign bit_end  = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign byte_end = bit_end && bit_cnt == 4'd9;

    // Sequencer: read a word, shift its two bytes out back-to-back, repeat; the
    // next start bit is loaded on the same edge the previous stop bit ends.
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            idx         <= '0;
            lo_byte     <= '0;
            sh          <= '1;
            bit_cnt     <= '0;
            clk_cnt     <= '0;
            lat         <= '0;
            mem_addr    <= '0;
            mem_ce      <= 1'b0;
            dump_active <= 1'b0;
            uart_tx     <= 1'b1;
            done        <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (tx_busy) begin
                if (bit_end) begin
                    clk_cnt <= '0;
                    bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
                    if (!byte_end) begin
                        uart_tx <= sh[0];
                        sh      <= {1'b1, sh[8:1]};
                    end
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
            end
            case (state)
                IDLE: if (start) begin
                    base        <= base_addr;
                    idx         <= '0;
                    mem_addr    <= base_addr;
                    mem_ce      <= 1'b1;
                    lat         <= '0;
                    dump_active <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum        <= '0;
`endif
                    state       <= RD_ADDR;
                end
                RD_ADDR: state <= RD_WAIT;
                RD_WAIT: if (lat == 2'(READ_LATENCY - 1)) begin
                    lo_byte <= mem_dout[7:0];
                    mem_ce  <= 1'b0;
                    uart_tx <= 1'b0;
                    sh      <= {1'b1, mem_dout[15:8]};
`ifdef DUMP_CHECKSUM_EN
                    csum    <= csum ^ mem_dout[15:8];
`endif
                    state   <= TX_HI;
                end else begin
                    lat <= lat + 2'd1;
                end
                TX_HI: if (byte_end) begin
                    uart_tx <= 1'b0;
                    sh      <= {1'b1, lo_byte};
`ifdef DUMP_CHECKSUM_EN
                    csum    <= csum ^ lo_byte;
`endif
                    state   <= TX_LO;
                end
                TX_LO: if (byte_end) begin
                    if (idx == 11'(WORD_COUNT - 1)) begin
`ifdef DUMP_CHECKSUM_EN
                        uart_tx     <= 1'b0;
                        sh          <= {1'b1, csum};
                        state       <= CSUM;
`else
                        done        <= 1'b1;
                        dump_active <= 1'b0;
                        state       <= FINISH;
`endif
                    end else begin
                        idx      <= idx + 11'd1;
                        mem_addr <= base + idx + 11'd1;
                        mem_ce   <= 1'b1;
                        lat      <= '0;
                        state    <= RD_ADDR;
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: if (byte_end) begin
                    done        <= 1'b1;
                    dump_active <= 1'b0;
                    state       <= FINISH;
                end
`endif
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bsram_dump.sv
// tb_bsram_dump: directed bench for bsram_dump with CLKS_PER_BIT=4, WORD_COUNT=2, READ_LATENCY=1.
module tb_bsram_dump;
    logic        clk_mem = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [10:0] mem_addr;
    logic        mem_ce, mem_wre, dump_active, uart_tx, done;
    logic [15:0] mem_dout;

    logic [15:0] mem [0:2047];
    int cyc = 0, cmp = 0, errs = 0, done_cnt = 0, ce_cnt = 0, wre_bad = 0;
    logic [8:0]  rxq [$];
    int          rxt [$];
    logic [10:0] aq [$];
    logic        ce_d = 1'b0;

    bsram_dump #(.CLKS_PER_BIT(4), .WORD_COUNT(2), .READ_LATENCY(1)) dut (
        .clk_mem(clk_mem), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_dout(mem_dout),
        .dump_active(dump_active), .uart_tx(uart_tx), .done(done)
    );

    always #5 clk_mem = ~clk_mem;

    always @(posedge clk_mem) begin
        cyc++;
        mem_dout <= mem_ce ? mem[mem_addr] : 16'hBEEF;
    end

    always @(negedge clk_mem) begin
        if (done === 1'b1) done_cnt++;
        if (mem_wre !== 1'b0) wre_bad++;
        if (mem_ce === 1'b1) ce_cnt++;
        if (mem_ce === 1'b1 && ce_d !== 1'b1) aq.push_back(mem_addr);
        ce_d = mem_ce;
    end

    always begin
        logic [7:0] b;
        logic       ok;
        int         t;
        @(negedge clk_mem);
        if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            t = cyc;
            repeat (2) @(negedge clk_mem);
            ok = uart_tx === 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk_mem);
                b[i] = uart_tx;
            end
            repeat (4) @(negedge clk_mem);
            ok = ok && uart_tx === 1'b1;
            rxq.push_back({ok, b});
            rxt.push_back(t);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [10:0] b, input bit dbl);
        int n = 0;
        int d0 = done_cnt;
        ce_cnt = 0;
        aq.delete();
        rxq.delete();
        rxt.delete();
        @(posedge clk_mem); #1 base_addr = b; start = 1'b1;
        @(posedge clk_mem); #1 start = 1'b0; base_addr = 11'h555;
        chk("active_rise", dump_active, 1);
        if (dbl) begin
            repeat (9) @(posedge clk_mem);
            #1 start = 1'b1; base_addr = 11'h123;
            @(posedge clk_mem); #1 start = 1'b0;
        end
        while (done !== 1'b1 && n < 600) begin
            @(negedge clk_mem);
            n++;
        end
        chk("done_seen", done, 1);
        chk("active_fall", dump_active, 0);
        @(negedge clk_mem);
        chk("done_pulse", done, 0);
        repeat (5) @(negedge clk_mem);
        chk("done_count", done_cnt - d0, 1);
        chk("ce_cycles", ce_cnt, 4);
    endtask

    task automatic check_bytes(input logic [7:0] b0, b1, b2, b3, input logic [10:0] a0, a1);
        logic [7:0] e [5];
        int n = 4;
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b0 ^ b1 ^ b2 ^ b3;
`ifdef DUMP_CHECKSUM_EN
        n = 5;
`endif
        chk("rx_count", rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), rxq[i], {1'b1, e[i]});
            if (i > 0) chk($sformatf("byte_gap%0d", i), rxt[i] - rxt[i-1], i == 2 ? 42 : 40);
        end
        chk("addr_count", aq.size(), 2);
        if (aq.size() == 2) begin
            chk("addr0", aq[0], a0);
            chk("addr1", aq[1], a1);
        end
        rxq.delete();
        rxt.delete();
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_tx", uart_tx, 1);
        chk("rst_active", dump_active, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_wre", mem_wre, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk_mem); rst_n = 1'b1;
        repeat (3) @(negedge clk_mem);
        chk("idle_after_rst", dump_active, 0);

        mem[0] = 16'h00A1; mem[1] = 16'h0078;
        run(11'h000, 1'b0);
        check_bytes(8'h00, 8'hA1, 8'h00, 8'h78, 11'h000, 11'h001);

        mem[11'h7FF] = 16'h1234; mem[0] = 16'h5678;
        run(11'h7FF, 1'b0);
        check_bytes(8'h12, 8'h34, 8'h56, 8'h78, 11'h7FF, 11'h000);

        mem[0] = 16'h00A1;
        run(11'h000, 1'b1);
        check_bytes(8'h00, 8'hA1, 8'h00, 8'h78, 11'h000, 11'h001);

        d0 = done_cnt;
        @(posedge clk_mem); #1 base_addr = 11'h000; start = 1'b1;
        @(posedge clk_mem); #1 start = 1'b0;
        repeat (11) @(posedge clk_mem);
        #2;
        chk("mid_frame_tx", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", uart_tx, 1);
        chk("abort_active", dump_active, 0);
        chk("abort_done", done, 0);
        chk("abort_ce", mem_ce, 0);
        repeat (3) @(negedge clk_mem);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_mem);
        chk("no_done_abort", done_cnt - d0, 0);
        chk("idle_after_abort", dump_active, 0);

        run(11'h000, 1'b0);
        check_bytes(8'h00, 8'hA1, 8'h00, 8'h78, 11'h000, 11'h001);
        chk("wre_never", wre_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/bsram_dump.md
BSRAM_DUMP -- requirements
Module: bsram_dump

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk_mem cycles per UART bit (27 MHz / 115200).
REQ-002 Parameter WORD_COUNT, default 16, number of 16-bit words dumped per run, legal range 1..2048.
REQ-003 Parameter READ_LATENCY, default 1, rising edges from address/ce presented to valid dout, legal 1..2.
REQ-004 clk_mem  input  1  system/memory clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a dump.
REQ-007 base_addr  input  11  first BSRAM word address, sampled on accepted start.
REQ-008 mem_addr  output  11  BSRAM address, muxed into ad while dump_active.
REQ-009 mem_ce  output  1  BSRAM chip enable.
REQ-010 mem_wre  output  1  BSRAM write enable, tied 0.
REQ-011 mem_dout  input  16  BSRAM read data.
REQ-012 dump_active  output  1  high while the block owns the BSRAM port; the top-level mux selects mem_addr when high.
REQ-013 uart_tx  output  1  serial 8N1 output, idle high.
REQ-014 done  output  1  one-cycle pulse after the final stop bit.

Function
REQ-015 FSM states: IDLE, RD_ADDR, RD_WAIT, TX_HI, TX_LO, CSUM, FINISH.
- IDLE: start=1 -> latch base_addr, clear word index, clear checksum, dump_active=1, go RD_ADDR.
- RD_ADDR: drive mem_addr=(base+index) mod 2048, mem_ce=1, go RD_WAIT.
- RD_WAIT: hold for READ_LATENCY cycles; capture mem_dout into word register on the last cycle; go TX_HI.
- TX_HI: send word[15:8]; TX_LO: send word[7:0].
- After TX_LO: index==WORD_COUNT-1 -> CSUM (macro on) or FINISH; otherwise index+1, go RD_ADDR.
- FINISH: done=1 for exactly one cycle, dump_active=0, go IDLE.
REQ-016 Address arithmetic is 11-bit; base_addr+index wraps 0x7FF -> 0x000 with no error.
REQ-017 UART framing: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles; byte period = 10*CLKS_PER_BIT cycles.
REQ-018 Consecutive bytes of a word are back-to-back with no idle gap; each inter-word gap = 1 + READ_LATENCY cycles of uart_tx high.
REQ-019 start while dump_active=1 is ignored and does not restart, extend or corrupt the current dump.
REQ-020 mem_ce=1 only in RD_ADDR and RD_WAIT; mem_wre=0 always; mem_addr holds its last value elsewhere.
REQ-021 dump_active rises the cycle after an accepted start and falls the same cycle done pulses.
REQ-022 The captured word is not affected by mem_dout changes after capture.

Reset
REQ-023 rst_n low asynchronously forces: state IDLE, uart_tx=1, dump_active=0, done=0, mem_ce=0, mem_wre=0, mem_addr=0, index=0, checksum=0.
REQ-024 Reset asserted mid-byte aborts the frame immediately with uart_tx=1; no done pulse is generated for the aborted run.
REQ-025 After rst_n release the block stays in IDLE until the next start pulse.

Configuration
REQ-026 Macro DUMP_CHECKSUM_EN defined: the block keeps a running 8-bit XOR of every transmitted data byte and sends it as one extra byte in state CSUM before FINISH.
REQ-027 DUMP_CHECKSUM_EN undefined: no CSUM state, no checksum register, and a run is exactly 2*WORD_COUNT bytes.

Verification (CLKS_PER_BIT=4, WORD_COUNT=2, READ_LATENCY=1, BSRAM model preloaded)
REQ-028 mem[0]=0x00A1, mem[1]=0x0078, start with base=0 -> bytes 0x00,0xA1,0x00,0x78 decoded, each 40 cycles, then done pulse; with macro also byte 0xD9.
REQ-029 base=0x7FF, mem[0x7FF]=0x1234, mem[0]=0x5678 -> bytes 0x12,0x34,0x56,0x78; mem_addr goes 0x7FF then 0x000.
REQ-030 Second start pulse 10 cycles into a run -> identical byte stream and exactly one done pulse.
REQ-031 rst_n low during the second data bit of byte 1 -> uart_tx=1 and dump_active=0 in the same cycle, no done pulse; a new start afterwards gives a full correct dump.
REQ-032 Throughout all runs: mem_wre=0, mem_ce high only in read cycles, and dump_active high from the cycle after start until done.
